// File: rtl/pulse_peak_detector.sv
// pulse_peak_detector: finds peak amplitude/time of threshold-crossing pulses in a shaped sample stream
// Ports: clk/reset (sync, active-high); filter_data, threshold: signed samples and trigger level;
//        peak_amp/peak_time/peak_trunc/peak_valid with peak_ready: one-entry result slot;
//        lost_pulse/lost_count: dropped-result strobe and saturating count; busy: pulse or dead time in progress.
module pulse_peak_detector #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int SIZE_TIME        = 16,
  parameter int HOLDOFF          = 8,
  parameter int MAX_WIDTH        = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amp,
  output logic        [SIZE_TIME-1:0]        peak_time,
  output logic                               peak_trunc,
  output logic                               peak_valid,
  input  logic                               peak_ready,
  output logic                               lost_pulse,
  output logic        [7:0]                  lost_count,
  output logic                               busy
);
  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam logic [WW-1:0] W_LAST = WW'(MAX_WIDTH - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
  typedef enum logic [1:0] {IDLE, RISE, HOLD} state_t;
  state_t state, state_n;
  logic        [SIZE_TIME-1:0]        ts, max_time, emit_time;
  logic signed [SIZE_FILTER_DATA-1:0] prev, max_amp, emit_amp;
  logic        [WW-1:0]               width;
  logic        [HW-1:0]               hold_cnt;
  logic above, trig, upd, emit, lost, load;
  assign above = filter_data > threshold;
  assign trig  = above && !(prev > threshold);
  assign busy  = state != IDLE;
  // Strictly greater keeps the first occurrence of a tied maximum; a below-threshold
  // sample can never exceed a max that is above threshold, so it is never folded in.
  always_comb begin
    upd       = 1'b0;
    emit      = 1'b0;
    state_n   = state;
    upd       = above && filter_data > max_amp;
    emit_amp  = upd ? filter_data : max_amp;
    emit_time = upd ? ts : max_time;
    emit      = state == RISE && (!above || width >= W_LAST);
    state_n   = emit ? HOLD :
                (state == IDLE && trig) ? RISE :
                (state == HOLD && hold_cnt == H_LAST) ? IDLE : state;
  end
  assign lost = emit && peak_valid && !peak_ready;
  assign load = emit && !lost;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ts         <= '0;
      prev       <= '0;
      max_amp    <= '0;
      max_time   <= '0;
      width      <= '0;
      hold_cnt   <= '0;
      peak_amp   <= '0;
      peak_time  <= '0;
      peak_trunc <= 1'b0;
      peak_valid <= 1'b0;
      lost_pulse <= 1'b0;
      lost_count <= '0;
    end else begin
      state      <= state_n;
      ts         <= ts + SIZE_TIME'(1);
      prev       <= filter_data;
      hold_cnt   <= state == HOLD ? hold_cnt + HW'(1) : '0;
      lost_pulse <= lost;
      if (lost && lost_count != 8'hff) lost_count <= lost_count + 8'd1;
      // Tracking registers preload every idle cycle so they are primed at the trigger edge.
      if (state == IDLE) begin
        max_amp  <= filter_data;
        max_time <= ts;
        width    <= WW'(1);
      end else if (state == RISE) begin
        max_amp  <= emit_amp;
        max_time <= emit_time;
        width    <= width + WW'(1);
      end
      if (load) begin
        peak_valid <= 1'b1;
        peak_amp   <= emit_amp;
        peak_time  <= emit_time;
        peak_trunc <= above;
      end else if (peak_ready) begin
        peak_valid <= 1'b0;
      end
    end
  end
endmodule
